vend_txn_ctrl: RTL and testbench



---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_timer.sv | 19 +
 rtl/vend_txn_ctrl.sv | 159 +++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;
  localparam int MONEY_W = 8;
  localparam logic [MONEY_W-1:0] MONEY_MAX  = 8'd99;
  localparam logic [MONEY_W-1:0] COIN1_VAL  = 8'd1;
  localparam logic [MONEY_W-1:0] COIN5_VAL  = 8'd5;
  localparam logic [MONEY_W-1:0] COIN10_VAL = 8'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAY    = 3'd1,
    ST_VEND   = 3'd2,
    ST_SHOW   = 3'd3,
    ST_REFUND = 3'd4
  } state_t;

  function automatic logic [MONEY_W-1:0] coin_sum(input logic c1, input logic c5, input logic c10);
    coin_sum = (c1 ? COIN1_VAL : '0) + (c5 ? COIN5_VAL : '0) + (c10 ? COIN10_VAL : '0);
  endfunction
endpackage

// File: rtl/vend_timer.sv
// Loadable 32-bit down-counter; expire is high in the cycle the count goes 1 -> 0.
module vend_timer (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expire
);
  logic [31:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)         cnt_q <= '0;
    else if (load)          cnt_q <= (load_val == 32'd0) ? 32'd1 : load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 32'd1;
  end

  // A reload in the expiring cycle cancels the expiry.
  assign expire = (cnt_q == 32'd1) && !load;
endmodule

// File: rtl/vend_txn_ctrl.sv
// Purchase sequencer: select -> pay -> vend/refund -> show result -> idle.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter logic [7:0]  PRICE0         = 8'd25,
  parameter logic [7:0]  PRICE1         = 8'd35,
  parameter logic [7:0]  PRICE2         = 8'd50,
  parameter logic [7:0]  PRICE3         = 8'd99,
  parameter logic [31:0] HOLD_CYCLES    = 32'd300_000_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               coin_1,
  input  logic               coin_5,
  input  logic               coin_10,
  input  logic               sel_valid,
  input  logic [1:0]         sel_idx,
  input  logic               cancel,
  output logic [MONEY_W-1:0] need_money,
  output logic [MONEY_W-1:0] input_money,
  output logic [MONEY_W-1:0] change_money,
  output logic [2:0]         state_o,
  output logic               dispense,
  output logic               refund,
  output logic               coin_reject,
  output logic               busy
);
  state_t             state_q;
  logic [MONEY_W-1:0] need_q, input_q, change_q;
  logic               disp_q, refund_q, rej_q, busy_q;

  logic [MONEY_W-1:0] csum, sum_d, price;
  logic               paid, fits, coin_any, accept;
  logic               tmr_load, tmr_exp;
  logic [31:0]        tmr_val;

  assign csum     = coin_sum(coin_1, coin_5, coin_10);
  assign coin_any = (csum != '0);
  assign sum_d    = input_q + csum;
  assign fits     = (sum_d <= MONEY_MAX);
  assign paid     = (input_q >= need_q);
  assign accept   = (state_q == ST_PAY) && !paid && coin_any && fits;

  always_comb begin
    price = PRICE0;
    case (sel_idx)
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      2'd3:    price = PRICE3;
      default: price = PRICE0;
    endcase
  end

  // Timeout is armed on PAY entry and on each accepted coin; hold on VEND/REFUND.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TIMEOUT_CYCLES;
    case (state_q)
      ST_IDLE:             tmr_load = sel_valid;
      ST_PAY:              tmr_load = accept;
      ST_VEND, ST_REFUND: begin
        tmr_load = 1'b1;
        tmr_val  = HOLD_CYCLES;
      end
      default:             tmr_load = 1'b0;
    endcase
  end

  vend_timer u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .expire    (tmr_exp)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      need_q   <= '0;
      input_q  <= '0;
      change_q <= '0;
      disp_q   <= 1'b0;
      refund_q <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      disp_q   <= 1'b0;
      refund_q <= 1'b0;
      rej_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rej_q <= coin_any;
          if (sel_valid) begin
            state_q  <= ST_PAY;
            need_q   <= price;
            input_q  <= '0;
            change_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_PAY: begin
          if (paid) begin
            state_q <= ST_VEND;
            rej_q   <= coin_any;
          end else begin
            if (coin_any) begin
              if (fits) input_q <= sum_d;
              else      rej_q   <= 1'b1;
            end
            // input_q above already includes a coin taken alongside cancel.
            if (cancel || (tmr_exp && !accept)) state_q <= ST_REFUND;
          end
        end
        ST_VEND: begin
          change_q <= paid ? (input_q - need_q) : '0;
          disp_q   <= 1'b1;
          rej_q    <= coin_any;
          state_q  <= ST_SHOW;
        end
        ST_REFUND: begin
          change_q <= input_q;
          input_q  <= '0;
          need_q   <= '0;
          refund_q <= 1'b1;
          rej_q    <= coin_any;
          state_q  <= ST_SHOW;
        end
        ST_SHOW: begin
          rej_q <= coin_any;
          if (tmr_exp) begin
            state_q  <= ST_IDLE;
            need_q   <= '0;
            input_q  <= '0;
            change_q <= '0;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          need_q   <= '0;
          input_q  <= '0;
          change_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign need_money   = need_q;
  assign input_money  = input_q;
  assign change_money = change_q;
  assign state_o      = state_q;
  assign dispense     = disp_q;
  assign refund       = refund_q;
  assign coin_reject  = rej_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with a scoreboard of expected output pulses.
module tb_vend_txn_ctrl;
  localparam int HOLD = 20;
  localparam int TOUT = 50;
  localparam int EV_DISP = 0, EV_REF = 1, EV_REJ = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       coin_1 = 0, coin_5 = 0, coin_10 = 0, sel_valid = 0, cancel = 0;
  logic [1:0] sel_idx = '0;
  logic [7:0] need_money, input_money, change_money;
  logic [2:0] state_o;
  logic       dispense, refund, coin_reject, busy;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         kind;
    logic [7:0] chg;
    logic [7:0] inm;
    logic [7:0] need;
  } ev_t;
  ev_t exp_q[$];

  vend_txn_ctrl #(
    .HOLD_CYCLES    (32'd20),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .coin_1       (coin_1),
    .coin_5       (coin_5),
    .coin_10      (coin_10),
    .sel_valid    (sel_valid),
    .sel_idx      (sel_idx),
    .cancel       (cancel),
    .need_money   (need_money),
    .input_money  (input_money),
    .change_money (change_money),
    .state_o      (state_o),
    .dispense     (dispense),
    .refund       (refund),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] chg, input logic [7:0] inm, input logic [7:0] need);
    ev_t e;
    e.kind = kind; e.chg = chg; e.inm = inm; e.need = need;
    exp_q.push_back(e);
  endtask

  task automatic score(input int kind);
    ev_t e;
    chk("evt_expected", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("evt_kind",   kind,         e.kind);
      chk("evt_change", change_money, e.chg);
      chk("evt_input",  input_money,  e.inm);
      chk("evt_need",   need_money,   e.need);
    end
  endtask

  // Output pulses are sampled mid-cycle and matched against the scoreboard.
  always @(negedge sys_clk) begin
    if (dispense)    score(EV_DISP);
    if (refund)      score(EV_REF);
    if (coin_reject) score(EV_REJ);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input logic c1, input logic c5, input logic c10, input logic can,
                       input logic sel, input logic [1:0] idx);
    coin_1 = c1; coin_5 = c5; coin_10 = c10; cancel = can; sel_valid = sel; sel_idx = idx;
    step();
    coin_1 = 0; coin_5 = 0; coin_10 = 0; cancel = 0; sel_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (state_o != 3'd0 && n < 300) begin step(); n++; end
    chk(tag, state_o, 0);
    chk({tag, "_money"}, {need_money, input_money, change_money}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #2;
    chk("rst_state", state_o, 0);
    chk("rst_money", {need_money, input_money, change_money}, 0);
    chk("rst_pulses", {dispense, refund, coin_reject, busy}, 0);
    #21 sys_rst_n = 1'b1;
    step();
    chk("post_rst_pulses", {dispense, refund, coin_reject}, 0);

    // Normal vend, exact payment
    drive(0, 0, 0, 0, 1, 2'd1);
    chk("sel_state", state_o, 1);
    chk("sel_need", need_money, 35);
    chk("sel_busy", busy, 1);
    repeat (3) drive(0, 0, 1, 0, 0, 2'd0);
    chk("pay_30", input_money, 30);
    push(EV_DISP, 8'd0, 8'd35, 8'd35);
    drive(0, 1, 0, 0, 0, 2'd0);
    chk("pay_35", input_money, 35);
    chk("pay_still", state_o, 1);
    step();
    chk("vend_state", state_o, 2);
    step();
    chk("show_state", state_o, 3);
    chk("exact_change", change_money, 0);
    n = 0;
    while (state_o == 3'd3 && n < 100) begin step(); n++; end
    chk("show_len", n, HOLD);
    wait_idle("idle_after_vend");

    // Overpay
    drive(0, 0, 0, 0, 1, 2'd0);
    drive(0, 0, 1, 0, 0, 2'd0);
    drive(0, 0, 1, 0, 0, 2'd0);
    push(EV_DISP, 8'd5, 8'd30, 8'd25);
    drive(0, 0, 1, 0, 0, 2'd0);
    chk("over_input", input_money, 30);
    wait_idle("idle_after_over");

    // Cancel with a coin in the same cycle
    drive(0, 0, 0, 0, 1, 2'd2);
    chk("cancel_need", need_money, 50);
    drive(0, 0, 1, 0, 0, 2'd0);
    push(EV_REF, 8'd15, 8'd0, 8'd0);
    drive(0, 1, 0, 1, 0, 2'd0);
    chk("cancel_state", state_o, 4);
    chk("cancel_input", input_money, 15);
    wait_idle("idle_after_cancel");

    // Saturation near 99
    drive(0, 0, 0, 0, 1, 2'd3);
    repeat (9) drive(0, 0, 1, 0, 0, 2'd0);
    chk("sat_90", input_money, 90);
    push(EV_REJ, 8'd0, 8'd90, 8'd99);
    drive(0, 0, 1, 0, 0, 2'd0);
    chk("sat_rej_hold", input_money, 90);
    drive(1, 1, 0, 0, 0, 2'd0);
    chk("sat_96", input_money, 96);
    push(EV_REJ, 8'd0, 8'd96, 8'd99);
    drive(0, 1, 0, 0, 0, 2'd0);
    chk("sat_rej2_hold", input_money, 96);
    chk("sat_state", state_o, 1);
    push(EV_REF, 8'd96, 8'd0, 8'd0);
    drive(0, 0, 0, 1, 0, 2'd0);
    wait_idle("idle_after_sat");

    // Timeout auto-refund
    drive(0, 0, 0, 0, 1, 2'd0);
    push(EV_REF, 8'd5, 8'd0, 8'd0);
    drive(0, 1, 0, 0, 0, 2'd0);
    n = 0;
    while (state_o != 3'd4 && n < 200) begin step(); n++; end
    chk("timeout_len", n, TOUT);
    step();
    chk("timeout_change", change_money, 5);
    wait_idle("idle_after_timeout");

    // Coin in IDLE is rejected without leaving IDLE
    push(EV_REJ, 8'd0, 8'd0, 8'd0);
    drive(1, 0, 0, 0, 0, 2'd0);
    chk("idle_rej_state", state_o, 0);
    chk("idle_rej_busy", busy, 0);
    step();

    // Asynchronous reset in the middle of PAY
    drive(0, 0, 0, 0, 1, 2'd1);
    drive(0, 0, 1, 0, 0, 2'd0);
    chk("pre_rst_input", input_money, 10);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_state", state_o, 0);
    chk("async_rst_money", {need_money, input_money, change_money}, 0);
    chk("async_rst_busy", busy, 0);
    repeat (3) step();
    #2 sys_rst_n = 1'b1;
    repeat (60) step();
    chk("after_rst_state", state_o, 0);
    chk("after_rst_money", {need_money, input_money, change_money}, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
